load_store_unit: RTL and testbench

- MEM-stage data-access engine of the 5-stage RISC-V core, sitting directly downstream of the EX/MEM pipeline register.
- Consumes the EX/MEM address, store data and memory control bits, and drives a request/grant/response data-memory bus.
- Generates byte strobes, aligns and sign-extends load data, and stalls the pipeline until each access completes.
- Its results feed the MEM/WB register.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_align.sv | 65 ++++++
 rtl/load_store_unit.sv | 161 ++++++++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, FSM states,
// the registered data-bus request payload and the funct3 legality check.
package lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
  } dmem_req_t;

  // Unsigned variants exist only for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !is_store;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables, store-data replication,
// alignment check, and load lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]      i_addr_lo,
  input  logic [1:0]      i_size,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [1:0]      i_ld_addr_lo,
  input  logic [2:0]      i_ld_funct3,
  input  logic [XLEN-1:0] i_rdata,
  output logic [BE_W-1:0] o_be_c,
  output logic [XLEN-1:0] o_wdata_c,
  output logic            o_misaligned_c,
  output logic [XLEN-1:0] o_load_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be_c         = '0;
    o_wdata_c      = i_wdata;
    o_misaligned_c = 1'b0;
    case (i_size)
      2'b00: begin
        o_be_c    = BE_W'(4'b0001 << i_addr_lo);
        o_wdata_c = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_be_c         = BE_W'(4'b0011 << {i_addr_lo[1], 1'b0});
        o_wdata_c      = {2{i_wdata[15:0]}};
        o_misaligned_c = i_addr_lo[0];
      end
      2'b10: begin
        o_be_c         = '1;
        o_misaligned_c = |i_addr_lo;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_ld_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_load_c = i_rdata;
    case (i_ld_funct3)
      F3_B:    o_load_c = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_c = {24'b0, w_byte};
      F3_H:    o_load_c = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_c = {16'b0, w_half};
      default: o_load_c = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store engine: accepts one EX/MEM access in IDLE, runs it on the
// req/gnt/rvalid data bus, stalls the pipeline meanwhile, and aborts on timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_write_data_mem,
  input  logic [2:0]  in_funct3,
  input  logic        in_memread,
  input  logic        in_memwrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] out_load_data,
  output logic        out_stall,
  output logic        out_mem_fault
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t      r_state, w_state_nxt;
  logic            r_req, w_req_nxt;
  dmem_req_t       r_bus, w_bus_nxt;
  logic [1:0]      r_ld_lo, w_ld_lo_nxt;
  logic [2:0]      r_ld_f3, w_ld_f3_nxt;
  logic            r_is_load, w_is_load_nxt;
  logic [XLEN-1:0] r_load_data, w_load_nxt;
  logic            r_fault, w_fault_nxt;
  logic [TMO_W-1:0] r_tmo, w_tmo_nxt;

  logic [BE_W-1:0] w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_load;
  logic            w_misaligned;
  logic            w_access;
  logic            w_illegal;
  logic            w_tmo_hit;

  lsu_align u_align (
    .i_addr_lo      (in_alu_result[1:0]),
    .i_size         (in_funct3[1:0]),
    .i_wdata        (in_write_data_mem),
    .i_ld_addr_lo   (r_ld_lo),
    .i_ld_funct3    (r_ld_f3),
    .i_rdata        (dmem_rdata),
    .o_be_c         (w_be),
    .o_wdata_c      (w_wdata),
    .o_misaligned_c (w_misaligned),
    .o_load_c       (w_load)
  );

  assign w_access  = in_memread || in_memwrite;
  assign w_illegal = (in_memread && in_memwrite) || !f3_legal(in_funct3, in_memwrite);
  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  // Next-state, next-register values and the combinational stall.
  always_comb begin
    w_state_nxt   = r_state;
    w_req_nxt     = r_req;
    w_bus_nxt     = r_bus;
    w_ld_lo_nxt   = r_ld_lo;
    w_ld_f3_nxt   = r_ld_f3;
    w_is_load_nxt = r_is_load;
    w_load_nxt    = r_load_data;
    w_fault_nxt   = 1'b0;
    w_tmo_nxt     = r_tmo;
    out_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          if (w_illegal || w_misaligned) begin
            w_fault_nxt = 1'b1;
          end else begin
            out_stall       = 1'b1;
            w_req_nxt       = 1'b1;
            w_bus_nxt.we    = in_memwrite;
            w_bus_nxt.addr  = {in_alu_result[31:2], 2'b00};
            w_bus_nxt.wdata = w_wdata;
            w_bus_nxt.be    = w_be;
            w_ld_lo_nxt     = in_alu_result[1:0];
            w_ld_f3_nxt     = in_funct3;
            w_is_load_nxt   = in_memread;
            w_tmo_nxt       = '0;
            w_state_nxt     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        out_stall = 1'b1;
        w_tmo_nxt = r_tmo + TMO_W'(1);
        if (dmem_gnt && dmem_rvalid) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_DONE;
          if (r_is_load) w_load_nxt = w_load;
        end else if (w_tmo_hit) begin
          w_req_nxt   = 1'b0;
          w_fault_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (dmem_gnt) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        out_stall = 1'b1;
        w_tmo_nxt = r_tmo + TMO_W'(1);
        if (dmem_rvalid) begin
          w_state_nxt = ST_DONE;
          if (r_is_load) w_load_nxt = w_load;
        end else if (w_tmo_hit) begin
          w_fault_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_req       <= 1'b0;
      r_bus       <= '0;
      r_ld_lo     <= '0;
      r_ld_f3     <= '0;
      r_is_load   <= 1'b0;
      r_load_data <= '0;
      r_fault     <= 1'b0;
      r_tmo       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req       <= w_req_nxt;
      r_bus       <= w_bus_nxt;
      r_ld_lo     <= w_ld_lo_nxt;
      r_ld_f3     <= w_ld_f3_nxt;
      r_is_load   <= w_is_load_nxt;
      r_load_data <= w_load_nxt;
      r_fault     <= w_fault_nxt;
      r_tmo       <= w_tmo_nxt;
    end
  end

  assign dmem_req      = r_req;
  assign dmem_we       = r_bus.we;
  assign dmem_addr     = r_bus.addr;
  assign dmem_wdata    = r_bus.wdata;
  assign dmem_be       = r_bus.be;
  assign out_load_data = r_load_data;
  assign out_mem_fault = r_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a small bus responder grants one cycle after
// a request and answers one cycle after the grant; expected values are hand-computed.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in_alu_result;
  logic [31:0] in_write_data_mem;
  logic [2:0]  in_funct3;
  logic        in_memread;
  logic        in_memwrite;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] out_load_data;
  logic        out_stall;
  logic        out_mem_fault;

  load_store_unit #(.TIMEOUT_CYCLES(255)) dut (
    .clock             (clock),
    .reset             (reset),
    .in_alu_result     (in_alu_result),
    .in_write_data_mem (in_write_data_mem),
    .in_funct3         (in_funct3),
    .in_memread        (in_memread),
    .in_memwrite       (in_memwrite),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_be           (dmem_be),
    .dmem_gnt          (dmem_gnt),
    .dmem_rvalid       (dmem_rvalid),
    .dmem_rdata        (dmem_rdata),
    .out_load_data     (out_load_data),
    .out_stall         (out_stall),
    .out_mem_fault     (out_mem_fault)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Results of the most recent access.
  int          t_stall, t_fault, t_req;
  logic        t_done;
  logic [31:0] t_ld, t_addr, t_wdata;
  logic [3:0]  t_be;
  logic        t_we;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one access for a single cycle and play the bus side until DONE or max_cyc.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rword, input logic withhold, input int max_cyc);
    logic granted, responded;
    granted = 1'b0; responded = 1'b0;
    t_stall = 0; t_fault = 0; t_req = 0; t_done = 1'b0;
    t_ld = '0; t_addr = '0; t_wdata = '0; t_be = '0; t_we = 1'b0;
    @(posedge clock); #1;
    in_memread = rd; in_memwrite = wr; in_funct3 = f3;
    in_alu_result = addr; in_write_data_mem = wd; dmem_rdata = rword;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clock);
      if (out_mem_fault) t_fault++;
      if (dmem_req) begin
        if (t_req == 0) begin
          t_addr = dmem_addr; t_be = dmem_be; t_we = dmem_we; t_wdata = dmem_wdata;
        end
        t_req++;
      end
      if (out_stall) t_stall++;
      else if (t_stall > 0) begin
        t_done = 1'b1;
        t_ld = out_load_data;
        break;
      end
      dmem_rvalid = granted && !responded;
      if (dmem_rvalid) responded = 1'b1;
      dmem_gnt = dmem_req && !granted && !withhold;
      if (dmem_gnt) granted = 1'b1;
      @(posedge clock); #1;
      in_memread = 1'b0; in_memwrite = 1'b0;
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    in_memread = 1'b0; in_memwrite = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    in_alu_result = '0; in_write_data_mem = '0; in_funct3 = '0;
    in_memread = 1'b0; in_memwrite = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_req",   32'(dmem_req), 32'd0);
    check_eq("rst_stall", 32'(out_stall), 32'd0);
    check_eq("rst_fault", 32'(out_mem_fault), 32'd0);
    check_eq("rst_load",  out_load_data, 32'h0);
    check_eq("rst_be",    32'(dmem_be), 32'h0);
    check_eq("rst_addr",  dmem_addr, 32'h0);
    reset = 1'b0;

    // LW aligned
    do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 20);
    check_eq("lw_addr",  t_addr, 32'h100);
    check_eq("lw_be",    32'(t_be), 32'hF);
    check_eq("lw_we",    32'(t_we), 32'd0);
    check_eq("lw_stall", 32'(t_stall), 32'd3);
    check_eq("lw_done",  32'(t_done), 32'd1);
    check_eq("lw_data",  t_ld, 32'hDEADBEEF);

    // LB / LBU on lane 3
    do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1122, 1'b0, 20);
    check_eq("lb_addr", t_addr, 32'h100);
    check_eq("lb_data", t_ld, 32'hFFFFFF80);
    do_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1122, 1'b0, 20);
    check_eq("lbu_data", t_ld, 32'h00000080);

    // LH upper half, LHU lower half
    do_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF1122, 1'b0, 20);
    check_eq("lh_data", t_ld, 32'hFFFF80FF);
    do_access(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h80FF1122, 1'b0, 20);
    check_eq("lhu_data", t_ld, 32'h00001122);

    // SH upper half: load result must stay at the previous load
    do_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h55555555, 1'b0, 20);
    check_eq("sh_we",    32'(t_we), 32'd1);
    check_eq("sh_be",    32'(t_be), 32'hC);
    check_eq("sh_wdata", t_wdata, 32'hABCDABCD);
    check_eq("sh_addr",  t_addr, 32'h100);
    check_eq("sh_stall", 32'(t_stall), 32'd3);
    check_eq("sh_load",  t_ld, 32'h00001122);

    // SB lane 1
    do_access(1'b0, 1'b1, 3'b000, 32'h101, 32'h123456A5, 32'h0, 1'b0, 20);
    check_eq("sb_be",    32'(t_be), 32'h2);
    check_eq("sb_wdata", t_wdata, 32'hA5A5A5A5);

    // Misaligned LW
    do_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1'b0, 4);
    check_eq("mis_req",   32'(t_req), 32'd0);
    check_eq("mis_fault", 32'(t_fault), 32'd1);
    check_eq("mis_stall", 32'(t_stall), 32'd0);

    // Illegal: both read and write, undefined load funct3, unsigned store
    do_access(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 32'h0, 1'b0, 4);
    check_eq("both_fault", 32'(t_fault), 32'd1);
    check_eq("both_req",   32'(t_req), 32'd0);
    do_access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b0, 4);
    check_eq("f3ld_fault", 32'(t_fault), 32'd1);
    check_eq("f3ld_stall", 32'(t_stall), 32'd0);
    do_access(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1'b0, 4);
    check_eq("f3st_fault", 32'(t_fault), 32'd1);

    // Timeout: grant withheld; accept cycle plus 255 waiting cycles
    do_access(1'b1, 1'b0, 3'b010, 32'h180, 32'h0, 32'hCAFEF00D, 1'b1, 300);
    check_eq("tmo_stall", 32'(t_stall), 32'd256);
    check_eq("tmo_fault", 32'(t_fault), 32'd1);
    check_eq("tmo_req",   32'(dmem_req), 32'd0);
    check_eq("tmo_load",  t_ld, 32'h00001122);
    @(negedge clock);
    check_eq("tmo_pulse", 32'(out_mem_fault), 32'd0);
    @(posedge clock); #1;
    dmem_rvalid = 1'b1;
    @(posedge clock); #1;
    dmem_rvalid = 1'b0;
    @(negedge clock);
    check_eq("stray_stall", 32'(out_stall), 32'd0);
    check_eq("stray_req",   32'(dmem_req), 32'd0);
    check_eq("stray_load",  out_load_data, 32'h00001122);
    check_eq("stray_fault", 32'(out_mem_fault), 32'd0);

    // Reset while waiting for the response
    @(posedge clock); #1;
    in_memread = 1'b1; in_funct3 = 3'b010; in_alu_result = 32'h200; dmem_rdata = 32'hBAD0BAD0;
    @(posedge clock); #1;
    in_memread = 1'b0;
    @(negedge clock);
    check_eq("rw_req", 32'(dmem_req), 32'd1);
    dmem_gnt = 1'b1;
    @(posedge clock); #1;
    dmem_gnt = 1'b0;
    check_eq("rw_wait_stall", 32'(out_stall), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rw_rst_req",   32'(dmem_req), 32'd0);
    check_eq("rw_rst_stall", 32'(out_stall), 32'd0);
    check_eq("rw_rst_load",  out_load_data, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    dmem_rvalid = 1'b1;
    @(posedge clock); #1;
    dmem_rvalid = 1'b0;
    @(negedge clock);
    check_eq("rw_stray_stall", 32'(out_stall), 32'd0);
    check_eq("rw_stray_load",  out_load_data, 32'h0);

    do_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h12345678, 1'b0, 20);
    check_eq("post_addr",  t_addr, 32'h104);
    check_eq("post_stall", 32'(t_stall), 32'd3);
    check_eq("post_data",  t_ld, 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
